// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_pkg
// Description : Shared constants and helpers for the programmable divider.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_div_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DEF_WIDTH = 8;

    function automatic int unsigned half_of(input int unsigned d);
        return d >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_div_half_ext.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_half_ext
// Description : Falling-edge half-cycle extender that stretches the high phase
//               by half a clock when the divisor is odd.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div_half_ext (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic odd,
    output logic out
);

    logic r_ext;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_ext <= 1'b0;
        end else begin
            r_ext <= in & odd;
        end
    end

    assign out = r_ext;

endmodule
`default_nettype wire

// File: rtl/freq_divider_prog.sv
`default_nettype none
// ============================================================================
// Module      : freq_divider_prog
// Description : Runtime-programmable 50%-duty integer clock divider with
//               boundary-aligned divisor updates, period tick and load check.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] c_MIN_DIV = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_DEFAULT = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             r_out_pos;
    logic             r_tick;
    logic             r_load_err;

    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0] w_half;
    logic             w_out_neg;

    assign w_wrap    = (r_cnt == r_div_q - c_ONE);
    assign w_apply   = en & w_wrap;
    assign w_load_ok = load & (div_val >= c_MIN_DIV);
    assign w_cnt_n   = w_wrap ? '0 : r_cnt + c_ONE;

    // A same-edge load takes priority over the pending value at the boundary.
    always_comb begin
        w_div_next = r_div_q;
        if (w_apply) begin
            if (w_load_ok) begin
                w_div_next = div_val;
            end else if (r_pend) begin
                w_div_next = r_pend_val;
            end
        end
    end

    // Threshold uses the divisor that governs the period being entered.
    assign w_half = WIDTH'(half_of(32'(w_div_next)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_out_pos <= 1'b0;
            r_div_q   <= c_DEFAULT;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_apply;
            if (en) begin
                r_cnt     <= w_cnt_n;
                r_out_pos <= (w_cnt_n < w_half);
                r_div_q   <= w_div_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & (div_val < c_MIN_DIV);
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_load_ok) begin
                r_pend     <= 1'b1;
                r_pend_val <= div_val;
            end
        end
    end

    freq_div_half_ext u_half_ext (
        .clk (clk),
        .rst (rst),
        .in  (r_out_pos),
        .odd (r_div_q[0]),
        .out (w_out_neg)
    );

    assign out        = r_out_pos | w_out_neg;
    assign tick       = r_tick;
    assign div_active = r_div_q;
    assign load_err   = r_load_err;

endmodule
`default_nettype wire

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
- Runtime-programmable integer clock divider. It generates a 50%-duty divided output for any divisor from 2 to 2^WIDTH-1, even or odd, plus a one-cycle period tick.
- Successor to the fixed-N odd divider. It adds programmable divisor, exact 50% duty for odd N, glitch-free divisor change at period boundary, enable/freeze, and illegal-load reporting.
- Sits in the clock/timing utility layer and feeds baud/strobe generators and derived-clock logic.

Parameters:
- WIDTH, 8, bit width of the divisor and internal counter.
- DEFAULT_DIV, 5, divisor active after reset; must be in 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock; both edges are used internally.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  count enable; low freezes the divider.
- load  input  1  request to take div_val as the new divisor.
- div_val  input  WIDTH  requested divisor, sampled when load=1.
- out  output  1  divided clock, 50% duty.
- tick  output  1  one-clk pulse at the start of each output period.
- div_active  output  WIDTH  divisor currently in effect.
- load_err  output  1  one-clk pulse when a load is rejected.

Behaviour:
- Reset (async, rst=1) sets these values:
  - cnt=0, out_pos=0, out_neg=0, so out=0.
  - tick=0, load_err=0.
  - div_q=DEFAULT_DIV, pend=0, pend_val=0.
- Let D=div_q and H=D>>1.
- Counter, at each posedge with en=1:
  - If cnt==D-1, cnt becomes 0 (wrap). Otherwise cnt becomes cnt+1.
  - Define cnt_n as the value being written into cnt.
- out_pos, at posedge with en=1: out_pos <= (cnt_n < H_eff).
  - H_eff is taken from the divisor in effect after this edge: the new divisor on a wrap edge that applies one.
- out_neg, at negedge clk (async reset): out_neg <= out_pos & D[0].
- out = out_pos | out_neg.
  - Even D: high exactly D/2 cycles, low D/2.
  - Odd D: high (D-1)/2 + 0.5 cycles, low the same.
- tick is registered: tick <= en & (cnt==D-1). It is high during the cycle cnt==0 and coincides with the rising edge of out_pos.
- First period after reset is one cycle short, because cnt leaves 0 on the first edge. This is accepted and documented.
- en=0:
  - cnt, out_pos and div_q hold; tick=0.
  - out_neg still tracks out_pos, so out holds a steady level.
  - Loads are still accepted into pending.
- Load handling:
  - load=1 with div_val<2: rejected, load_err=1 for the next cycle, pending unchanged.
  - load=1 with div_val>=2: pend_val<=div_val, pend<=1. A later load before the boundary overwrites the earlier one (last wins).
- Apply rule, on a wrap edge (en=1, cnt==D-1):
  - If a valid load is present on that same edge, div_q<=div_val, which bypasses pending.
  - Else if pend=1, div_q<=pend_val.
  - In either case pend clears.
- A divisor never changes mid-period, so out has no runt pulses.
- div_active = div_q (registered). It updates in the same cycle as the tick of the new period.
- Reset mid-period: all state returns to reset values immediately and any pending load is discarded.
- Latency: the new divisor governs the first full period that starts after the current period ends.

Decomposition:
- Package freq_div_pkg holds:
  - MIN_DIV=2;
  - the default WIDTH constant;
  - a function half_of(D) returning D>>1.
- Sub-module freq_div_half_ext contains the negedge half-cycle extender.
  - Ports: clk, rst, in, odd, out.
  - This isolates the only negedge flop for timing and CDC review.
- All other logic (counter, pending register, apply rule, tick) stays in the top.

Test Plan:
- Reset release with D=5, en=1 -> after the first wrap, out is high 2.5 clk and low 2.5 clk, period 5. tick is high once every 5 cycles, aligned with the out rise.
- load=1, div_val=4 at cnt=1 -> current 5-period completes unchanged. Then out is high 2 / low 2, div_active=4 from the next tick, and no runt pulse.
- Two loads before a boundary, div_val=7 then 3 -> only 3 is applied at the boundary. Check out high 1.5 / low 1.5.
- load=1, div_val=1 (and separately 0) -> load_err pulses for 1 cycle, div_active is unchanged at 5, and the waveform is unaffected.
- en low for 6 cycles mid-high phase -> out stays high, tick=0, cnt frozen. After en returns, the period resumes with the remaining count.
- rst asserted at cnt=3 with a pending load of 6 -> out=0 and tick=0 immediately. After release, div_active=5 and the pending load is discarded.
